// File: rtl/md_issue.sv
// md_issue: decodes HI/LO-class ops, holds Md_op/operands for the muldiv unit, returns MFHI/MFLO/MUL results.
// Latency: accept -> ISSUE next edge; result writeback one cycle after Md_stall drops (or after ISSUE if no stall).
// Backpressure: Pipe_stall holds IF/ID/EX through ISSUE/WAIT; WAIT aborts after WAIT_MAX cycles (sticky Md_err).
// Optional: define MD_PERF_EN to add the Stall_cycles performance counter output.
module md_issue #(
  parameter int WAIT_MAX = 40,
  parameter int CNT_W    = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Instr_valid,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic [4:0]  Rd_addr,
  input  logic [31:0] Rs_data,
  input  logic [31:0] Rt_data,
  input  logic        Flush,
  input  logic        Md_stall,
  input  logic [31:0] Md_res,
  output logic [3:0]  Md_op,
  output logic [31:0] Rs_out,
  output logic [31:0] Rt_out,
  output logic        Pipe_stall,
  output logic        Wb_en,
  output logic [4:0]  Wb_addr,
  output logic [31:0] Wb_data,
  output logic        Md_err
`ifdef MD_PERF_EN
  ,
  output logic [31:0] Stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
  localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;

  state_t           state;
  logic [3:0]       dec_op;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             op_has_res;
  logic             accept;

  // Instruction decode into the muldiv op encoding; 0 means "not ours".
  always_comb begin
    dec_op = 4'b0000;
    if (Opcode == OPC_SPECIAL) begin
      case (Funct)
        6'b011010: dec_op = 4'b0001; // DIV
        6'b011011: dec_op = 4'b0010; // DIVU
        6'b010000: dec_op = 4'b0011; // MFHI
        6'b010010: dec_op = 4'b0100; // MFLO
        6'b010001: dec_op = 4'b0101; // MTHI
        6'b010011: dec_op = 4'b0110; // MTLO
        6'b011000: dec_op = 4'b1000; // MULT
        6'b011001: dec_op = 4'b1001; // MULTU
        default:   dec_op = 4'b0000;
      endcase
    end else if (Opcode == OPC_SPECIAL2 && Funct == 6'b000010) begin
      dec_op = 4'b0111;              // MUL
    end
  end

  // Md_op is the latched op while it is live, so it also tells us whether a result comes back.
  assign op_has_res = (Md_op == 4'b0011) || (Md_op == 4'b0100) || (Md_op == 4'b0111);

  // New ops are only taken when nothing is in flight; Flush squashes the slot.
  assign accept = Instr_valid && (dec_op != 4'b0000) && !Flush &&
                  ((state == S_IDLE) || (state == S_RESULT));

  assign Pipe_stall = (state == S_ISSUE) || (state == S_WAIT);

  // A flush in the RESULT cycle kills the writeback of the (younger-stage) result.
  assign Wb_en = (state == S_RESULT) && !Flush;

  // Sequencer: issue, wait on the unit with a timeout, then optional one-cycle result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      Md_op    <= 4'b0000;
      Rs_out   <= 32'd0;
      Rt_out   <= 32'd0;
      rd_q     <= 5'd0;
      Wb_addr  <= 5'd0;
      Wb_data  <= 32'd0;
      wait_cnt <= '0;
      Md_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RESULT: begin
          if (accept) begin
            Md_op  <= dec_op;
            Rs_out <= Rs_data;
            Rt_out <= Rt_data;
            rd_q   <= Rd_addr;
            state  <= S_ISSUE;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_ISSUE, S_WAIT: begin
          // Flush is deliberately ignored here: the op already owns HI/LO.
          if (Md_stall) begin
            if (state == S_ISSUE) begin
              wait_cnt <= CNT_W'(1);
              state    <= S_WAIT;
            end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
              wait_cnt <= '0;
              Md_op    <= 4'b0000;
              Md_err   <= 1'b1;
              state    <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end else begin
            wait_cnt <= '0;
            Md_op    <= 4'b0000;
            if (op_has_res) begin
              Wb_data <= Md_res;
              Wb_addr <= rd_q;
              state   <= S_RESULT;
            end else begin
              state   <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MD_PERF_EN
  // Free-running count of stalled cycles; wraps naturally at 2^32.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)           Stall_cycles <= 32'd0;
    else if (Pipe_stall) Stall_cycles <= Stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_md_issue.sv
// tb_md_issue: randomized + directed stimulus for md_issue with a transaction-level reference model.
// Driver pushes expected issues/writebacks into queues; a negedge monitor pops and compares.
// Ends with an asynchronous reset applied mid-WAIT.
`timescale 1ns/1ps
module tb_md_issue;

  localparam int WAIT_MAX = 40;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Instr_valid;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic [4:0]  Rd_addr;
  logic [31:0] Rs_data;
  logic [31:0] Rt_data;
  logic        Flush;
  logic        Md_stall;
  logic [31:0] Md_res;
  logic [3:0]  Md_op;
  logic [31:0] Rs_out;
  logic [31:0] Rt_out;
  logic        Pipe_stall;
  logic        Wb_en;
  logic [4:0]  Wb_addr;
  logic [31:0] Wb_data;
  logic        Md_err;
`ifdef MD_PERF_EN
  logic [31:0] Stall_cycles;
`endif

  always #5 Clk = ~Clk;

  md_issue #(.WAIT_MAX(WAIT_MAX), .CNT_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .Instr_valid(Instr_valid), .Opcode(Opcode), .Funct(Funct),
    .Rd_addr(Rd_addr), .Rs_data(Rs_data), .Rt_data(Rt_data), .Flush(Flush),
    .Md_stall(Md_stall), .Md_res(Md_res), .Md_op(Md_op), .Rs_out(Rs_out), .Rt_out(Rt_out),
    .Pipe_stall(Pipe_stall), .Wb_en(Wb_en), .Wb_addr(Wb_addr), .Wb_data(Wb_data),
    .Md_err(Md_err)
`ifdef MD_PERF_EN
    , .Stall_cycles(Stall_cycles)
`endif
  );

  typedef struct {
    logic        valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] res;
    logic        flush;
    int          nstall;
  } txn_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          len;
    logic        err;
  } iss_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  iss_t iss_q[$];
  wb_t  wb_q[$];

  int tests = 0;
  int fails = 0;

  // Driver-side model state.
  logic        in_result = 1'b0;
  wb_t         pend_wb;
  logic        exp_err = 1'b0;
  logic [31:0] stall_total = 32'd0;
  logic        mon_en = 1'b0;

  // Opcode/funct pairs that are muldiv ops, with their encodings.
  logic [11:0] md_code [9] = '{12'b000000_011010, 12'b000000_011011, 12'b000000_010000,
                               12'b000000_010010, 12'b000000_010001, 12'b000000_010011,
                               12'b000000_011000, 12'b000000_011001, 12'b011100_000010};
  logic [3:0]  md_enc  [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd7};

  function automatic logic [3:0] ref_op(input logic [5:0] opc, input logic [5:0] fn);
    logic [3:0] r = 4'd0;
    for (int i = 0; i < 9; i++)
      if (md_code[i] == {opc, fn}) r = md_enc[i];
    return r;
  endfunction

  function automatic logic ref_has_res(input logic [3:0] op);
    return (op == 4'd3) || (op == 4'd4) || (op == 4'd7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one instruction and, if it is accepted, play the muldiv unit for it.
  task automatic drive(input txn_t t);
    logic [3:0] op;
    int         len;
    logic       abort;
    @(negedge Clk);
    Instr_valid = t.valid;
    Opcode      = t.opcode;
    Funct       = t.funct;
    Rd_addr     = t.rd;
    Rs_data     = t.rs;
    Rt_data     = t.rt;
    Flush       = t.flush;
    Md_stall    = 1'b0;
    if (in_result) begin
      if (!t.flush) wb_q.push_back(pend_wb);
      in_result = 1'b0;
    end
    op = ref_op(t.opcode, t.funct);
    if (t.valid && op != 4'd0 && !t.flush) begin
      abort = (t.nstall > WAIT_MAX);
      len   = (abort ? WAIT_MAX : t.nstall) + 1;
      if (abort) exp_err = 1'b1;
      iss_q.push_back('{op: op, rs: t.rs, rt: t.rt, len: len, err: exp_err});
      stall_total = stall_total + 32'(len);
      for (int s = 0; s < len; s++) begin
        @(negedge Clk);
        // Busy cycles: random traffic in the slot and random flushes must be ignored.
        Instr_valid = 1'($urandom_range(0, 1));
        Opcode      = 6'b000000;
        Funct       = 6'b011000;
        Rd_addr     = 5'($urandom);
        Rs_data     = $urandom;
        Rt_data     = $urandom;
        Flush       = 1'($urandom_range(0, 1));
        Md_stall    = (s < t.nstall);
        Md_res      = t.res;
      end
      if (ref_has_res(op) && !abort) begin
        in_result = 1'b1;
        pend_wb   = '{addr: t.rd, data: t.res};
      end
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    int   k;
    if ($urandom_range(0, 9) < 7) begin
      k = $urandom_range(0, 8);
      {t.opcode, t.funct} = md_code[k];
    end else begin
      t.opcode = 6'($urandom);
      t.funct  = 6'($urandom);
      if (ref_op(t.opcode, t.funct) != 4'd0) t.funct = 6'b111111;
    end
    t.valid  = ($urandom_range(0, 9) != 0);
    t.flush  = ($urandom_range(0, 7) == 0);
    t.rd     = 5'($urandom);
    t.rs     = $urandom;
    t.rt     = $urandom;
    t.res    = $urandom;
    t.nstall = ($urandom_range(0, 24) == 0) ? $urandom_range(35, 45) : $urandom_range(0, 4);
    return t;
  endfunction

  // Monitor: compares issues, stall lengths, Md_op and writebacks against the queues.
  iss_t cur;
  logic have_cur = 1'b0;
  logic prev_ps  = 1'b0;
  int   cur_len  = 0;
  initial begin
    wb_t w;
    forever begin
      @(negedge Clk);
      #1;
      if (!mon_en) begin
        prev_ps  = 1'b0;
        have_cur = 1'b0;
      end else begin
        if (Pipe_stall && !prev_ps) begin
          if (iss_q.size() == 0) begin
            chk("unexpected_issue", 32'(Md_op), 32'd0);
            have_cur = 1'b0;
          end else begin
            cur      = iss_q.pop_front();
            have_cur = 1'b1;
            cur_len  = 0;
          end
        end
        if (Pipe_stall) begin
          cur_len++;
          if (have_cur) begin
            chk("md_op_live", 32'(Md_op), 32'(cur.op));
            chk("rs_out", Rs_out, cur.rs);
            chk("rt_out", Rt_out, cur.rt);
          end
        end else begin
          chk("md_op_idle", 32'(Md_op), 32'd0);
          if (prev_ps && have_cur) begin
            chk("stall_len", 32'(cur_len), 32'(cur.len));
            chk("md_err", 32'(Md_err), 32'(cur.err));
            have_cur = 1'b0;
          end
        end
        if (Wb_en) begin
          if (wb_q.size() == 0) begin
            chk("unexpected_wb", 32'(Wb_addr), 32'hFFFF_FFFF);
          end else begin
            w = wb_q.pop_front();
            chk("wb_addr", 32'(Wb_addr), 32'(w.addr));
            chk("wb_data", Wb_data, w.data);
          end
        end
        prev_ps = Pipe_stall;
      end
    end
  end

  initial begin
    txn_t t;
    Reset = 1'b1; Instr_valid = 1'b0; Opcode = '0; Funct = '0; Rd_addr = '0;
    Rs_data = '0; Rt_data = '0; Flush = 1'b0; Md_stall = 1'b0; Md_res = '0;
    #12;
    chk("rst_md_op", 32'(Md_op), 32'd0);
    chk("rst_pipe_stall", 32'(Pipe_stall), 32'd0);
    chk("rst_wb_en", 32'(Wb_en), 32'd0);
    chk("rst_wb_addr", 32'(Wb_addr), 32'd0);
    chk("rst_wb_data", Wb_data, 32'd0);
    chk("rst_rs_out", Rs_out, 32'd0);
    chk("rst_md_err", 32'(Md_err), 32'd0);
`ifdef MD_PERF_EN
    chk("rst_stall_cycles", Stall_cycles, 32'd0);
`endif
    @(negedge Clk);
    Reset  = 1'b0;
    mon_en = 1'b1;

    // Directed cases.
    drive('{valid: 1, opcode: 6'h00, funct: 6'b011000, rd: 5'd0, rs: 32'hFFFF_FFFE, rt: 32'd3,
            res: 32'd0, flush: 0, nstall: 0});                       // MULT, no stall
    drive('{valid: 1, opcode: 6'b011100, funct: 6'b000010, rd: 5'd8, rs: 32'd2, rt: 32'hFFFF_FFFD,
            res: 32'hFFFF_FFFA, flush: 0, nstall: 0});               // MUL -> rd 8
    drive('{valid: 1, opcode: 6'h00, funct: 6'b011010, rd: 5'd0, rs: 32'd100, rt: 32'd7,
            res: 32'd0, flush: 0, nstall: 33});                      // DIV, 34 stall cycles
    drive('{valid: 1, opcode: 6'h00, funct: 6'b010010, rd: 5'd2, rs: 32'd0, rt: 32'd0,
            res: 32'h1111_2222, flush: 0, nstall: 0});               // MFLO -> rd 2
    drive('{valid: 1, opcode: 6'h00, funct: 6'b010000, rd: 5'd3, rs: 32'd0, rt: 32'd0,
            res: 32'h3333_4444, flush: 0, nstall: 0});               // MFHI during MFLO RESULT
    drive('{valid: 0, opcode: 6'h00, funct: 6'h00, rd: 5'd0, rs: 32'd0, rt: 32'd0,
            res: 32'd0, flush: 1, nstall: 0});                       // flush kills MFHI writeback
    drive('{valid: 1, opcode: 6'h00, funct: 6'b011011, rd: 5'd0, rs: 32'd9, rt: 32'd0,
            res: 32'd0, flush: 0, nstall: 60});                      // DIVU stuck -> abort
    drive('{valid: 1, opcode: 6'h00, funct: 6'b011010, rd: 5'd1, rs: 32'd5, rt: 32'd5,
            res: 32'd0, flush: 1, nstall: 0});                       // flushed at accept

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      t = rand_txn();
      drive(t);
    end
    t = '{valid: 0, opcode: 6'h00, funct: 6'h00, rd: 5'd0, rs: 32'd0, rt: 32'd0,
          res: 32'd0, flush: 0, nstall: 0};
    drive(t);
    repeat (3) @(negedge Clk);
    #2;
    chk("iss_q_drained", 32'(iss_q.size()), 32'd0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
    chk("err_sticky", 32'(Md_err), 32'd1);
`ifdef MD_PERF_EN
    chk("stall_cycles_total", Stall_cycles, stall_total);
`endif

    // Asynchronous reset in the middle of a WAIT.
    mon_en = 1'b0;
    @(negedge Clk);
    Instr_valid = 1'b1; Opcode = 6'h00; Funct = 6'b011010; Flush = 1'b0; Md_stall = 1'b0;
    @(negedge Clk);
    Instr_valid = 1'b0; Md_stall = 1'b1;
    repeat (5) @(negedge Clk);
    #1;
    chk("pre_rst_md_op", 32'(Md_op), 32'd1);
    chk("pre_rst_pipe_stall", 32'(Pipe_stall), 32'd1);
    chk("pre_rst_err", 32'(Md_err), 32'd1);
    #1;
    Reset = 1'b1;
    #1;
    chk("mid_rst_md_op", 32'(Md_op), 32'd0);
    chk("mid_rst_pipe_stall", 32'(Pipe_stall), 32'd0);
    chk("mid_rst_wb_en", 32'(Wb_en), 32'd0);
    chk("mid_rst_err", 32'(Md_err), 32'd0);
`ifdef MD_PERF_EN
    chk("mid_rst_stall_cycles", Stall_cycles, 32'd0);
`endif
    @(negedge Clk);
    Reset = 1'b0; Md_stall = 1'b0;
    @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
